apb2axi: RTL and testbench
==========================

# apb2axi

Bridge from an APB requester to the AXI fabric. It is an APB completer on one side and a single-outstanding AXI master on the other. Each 32-bit APB access becomes exactly one single-beat 32-bit AXI transaction on the 64-bit data bus. It lets APB-only agents (debug port, boot sequencer) reach any target on the NoC, and is the counterpart of the bridge that drives APB peripherals from AXI.

## Interface
Parameters:
- AWID, 32, address width on both sides.
- IDWID, 4, AXI ID width.
- DWID, 64, AXI data width. Fixed at 64; APB data is DWID/2.
- AXI_ID, 0, constant ID driven on arid/awid.
- EXTRAS, 8, width of arextras/awextras. Driven 0.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- psel, penable, pwrite, in, 1 each, APB control.
- paddr, in, AWID, APB address.
- pwdata, in, 32, APB write data.
- pstrb, in, 4, APB byte strobes.
- pready, out, 1, access complete.
- prdata, out, 32, read data.
- pslverr, out, 1, error completion.
- arid, araddr, arlen, arsize, arburst, arextras, arvalid, out; arready, in. AXI read address channel.
- rid, rdata, rresp, rlast, rvalid, in; rready, out. AXI read data channel.
- awid, awaddr, awlen, awsize, awburst, awextras, awvalid, out; awready, in. AXI write address channel.
- wdata, wstrb, wlast, wvalid, out; wready, in. AXI write data channel.
- bid, bresp, bvalid, in; bready, out. AXI write response channel.

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- Launch: in IDLE, psel && penable → latch paddr, pwrite, pwdata, pstrb. Go to RADDR if read, WREQ if write.
- Setup phase (psel && !penable) is ignored.
- Fixed AXI fields: arlen/awlen=0, arsize/awsize=2, arburst/awburst=1 (INCR), wlast=1, IDs=AXI_ID. Addresses are the latched paddr, unmodified.
- Write lanes:
  - wdata={pwdata,pwdata}.
  - wstrb={pstrb,4'h0} if addr[2]=1, else {4'h0,pstrb}.
- RADDR: arvalid=1 until arready, then RDATA.
- RDATA: rready=1. On rvalid, capture rdata[63:32] if addr[2]=1, else rdata[31:0], into prdata.
  - err = (rresp!=0) || (rid!=AXI_ID) || !rlast.
  - Then DONE.
- WREQ: awvalid and wvalid are asserted together. Each drops independently on its own handshake (per-channel done flags). Move to WRESP once both are done, including the same-cycle case.
- WRESP: bready=1. On bvalid, err = (bresp!=0) || (bid!=AXI_ID). Then DONE.
- DONE: pready=1 and pslverr=err for exactly one cycle, then IDLE. A new access may launch no earlier than the cycle after DONE.
- At most one AXI transaction is outstanding. No timeout; the bridge waits indefinitely on AXI.
- Boundary cases:
  - rvalid/bvalid arriving outside RDATA/WRESP are not accepted (ready stays 0).
  - psel dropped mid-transaction (protocol violation): the AXI transaction still completes and pready still pulses.
  - Reset mid-transaction: all valids/readies and pready deassert immediately. The AXI side is the system's responsibility.

## Timing
- Reset values: all valid/ready outputs 0, pready 0, pslverr 0, prdata 0, state IDLE.
- Cycle 0 = first access-phase cycle. arvalid/awvalid/wvalid are registered and rise at cycle 1.
- Zero-wait read or write: pready at cycle 3 (cycle 1 handshake, cycle 2 response, cycle 3 DONE).
- Each AXI stall cycle adds one cycle.
- pready is low in every state except DONE. prdata holds its value until the next read completes.
- All outputs are registered or decoded from state only; no combinational path from AXI inputs to APB outputs.

## Structure
- Shared package apb2axi_pkg: state encoding, AXI constants (SIZE_4B=2, BURST_INCR=1, RESP_OKAY=0).
- Single module, no sub-module. No FIFOs are needed with one transaction outstanding.

## Test plan
- Read paddr=0x1004, AXI returns rdata=0x11223344_55667788, rresp=0, zero wait → araddr=0x1004, arsize=2; prdata=0x11223344, pready at cycle 3, pslverr=0.
- Write paddr=0x2000, pwdata=0xCAFEF00D, pstrb=0x3; awready at cycle 1, wready delayed to cycle 4 → wdata=0xCAFEF00D_CAFEF00D, wstrb=0x03; awvalid drops after cycle 1; WRESP at cycle 5; bvalid at cycle 5 → pready at cycle 6.
- Write to paddr=0x2004, pstrb=0xF → wstrb=0xF0.
- Read returning rresp=2 (SLVERR) → pslverr=1 with pready. Repeat with rresp=0 but rid≠AXI_ID → pslverr=1.
- Back-to-back APB read then write with 3-cycle AXI stalls → one outstanding at a time; second arvalid/awvalid only after the first DONE; ordering preserved.
- Assert rst_n=0 while in RDATA → rready, pready and arvalid are 0 in the same cycle. After release, a fresh read completes normally.

Source files
------------

// File: rtl/apb2axi_pkg.sv
// Shared definitions for the APB-to-AXI bridge: FSM state encoding,
// fixed AXI field values and the write-lane strobe helper.
package apb2axi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [1:0] RESP_OKAY  = 2'd0;

  // Place the 4-bit APB strobe on the upper or lower word of the 64-bit bus.
  function automatic logic [7:0] lane_strb(input logic hi, input logic [3:0] strb);
    return hi ? {strb, 4'h0} : {4'h0, strb};
  endfunction

endpackage

// File: rtl/apb2axi.sv
// APB completer that turns each 32-bit APB access into one single-beat
// 32-bit AXI transaction on a 64-bit bus, one transaction outstanding.
module apb2axi
  import apb2axi_pkg::*;
#(
  parameter int AWID   = 32,
  parameter int IDWID  = 4,
  parameter int DWID   = 64,
  parameter int AXI_ID = 0,
  parameter int EXTRAS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  // APB completer
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [AWID-1:0]     paddr,
  input  logic [DWID/2-1:0]   pwdata,
  input  logic [3:0]          pstrb,
  output logic                pready,
  output logic [DWID/2-1:0]   prdata,
  output logic                pslverr,
  // AXI read address
  output logic [IDWID-1:0]    arid,
  output logic [AWID-1:0]     araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [EXTRAS-1:0]   arextras,
  output logic                arvalid,
  input  logic                arready,
  // AXI read data
  input  logic [IDWID-1:0]    rid,
  input  logic [DWID-1:0]     rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address
  output logic [IDWID-1:0]    awid,
  output logic [AWID-1:0]     awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [EXTRAS-1:0]   awextras,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [DWID-1:0]     wdata,
  output logic [DWID/8-1:0]   wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [IDWID-1:0]    bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [IDWID-1:0] ID_C = IDWID'(AXI_ID);

  state_e              state_q,    state_d;
  logic [AWID-1:0]     addr_q,     addr_d;
  logic [DWID/2-1:0]   wdata_q,    wdata_d;
  logic [3:0]          strb_q,     strb_d;
  logic [DWID/2-1:0]   prdata_q,   prdata_d;
  logic                err_q,      err_d;
  logic                aw_done_q,  aw_done_d;
  logic                w_done_q,   w_done_d;

  // Next-state and datapath capture for the bridge FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = prdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        // Only the access phase launches; the setup phase is ignored.
        if (psel && penable) begin
          addr_d    = paddr;
          wdata_d   = pwdata;
          strb_d    = pstrb;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = pwrite ? WREQ : RADDR;
        end
      end
      RADDR: begin
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        if (rvalid) begin
          prdata_d = addr_q[2] ? rdata[DWID-1:DWID/2] : rdata[DWID/2-1:0];
          err_d    = (rresp != RESP_OKAY) || (rid != ID_C) || !rlast;
          state_d  = DONE;
        end
      end
      WREQ: begin
        // Address and data channels complete independently, possibly together.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (bvalid) begin
          err_d   = (bresp != RESP_OKAY) || (bid != ID_C);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Handshake outputs are decoded from registered state only.
  assign arvalid  = (state_q == RADDR);
  assign rready   = (state_q == RDATA);
  assign awvalid  = (state_q == WREQ) && !aw_done_q;
  assign wvalid   = (state_q == WREQ) && !w_done_q;
  assign bready   = (state_q == WRESP);
  assign pready   = (state_q == DONE);
  assign pslverr  = (state_q == DONE) && err_q;
  assign prdata   = prdata_q;

  assign arid     = ID_C;
  assign araddr   = addr_q;
  assign arlen    = 8'd0;
  assign arsize   = SIZE_4B;
  assign arburst  = BURST_INCR;
  assign arextras = '0;

  assign awid     = ID_C;
  assign awaddr   = addr_q;
  assign awlen    = 8'd0;
  assign awsize   = SIZE_4B;
  assign awburst  = BURST_INCR;
  assign awextras = '0;

  assign wdata    = {wdata_q, wdata_q};
  assign wstrb    = lane_strb(addr_q[2], strb_q);
  assign wlast    = 1'b1;

endmodule

// File: tb/tb_apb2axi.sv
// Directed bench for apb2axi: table of APB accesses with a cycle-accurate
// AXI responder, plus hand-written reset and setup-phase sequences.
module tb_apb2axi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen, arextras, awextras;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [7:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb2axi dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arextras(arextras), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awextras(awextras), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [63:0] rd;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    bit          rlast;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    int          ar_at, r_at, aw_at, w_at, b_at;  // first cycle each AXI side is ready/valid
    bit          drop;                            // drop psel right after launch
    logic [31:0] exp_prdata;
    bit          exp_err;
    logic [7:0]  exp_wstrb;
    int          exp_cyc;                         // cycle of pready, cycle 0 = access phase
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic axi_idle();
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rid = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit got = 0, ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
    bit seen_ar = 0, seen_aw = 0, seen_w = 0, excl_bad = 0;
    int awcnt = 0, wcnt = 0, pc = -1;
    logic [31:0] got_prdata = '0;
    logic        got_err = 0;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = v.wr; paddr = v.addr; pwdata = v.wd; pstrb = v.strb;
    @(negedge clk);
    penable = 1;  // cycle 0
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (v.drop) begin psel = 0; penable = 0; end
      if (v.wr && (arvalid || rready)) excl_bad = 1;
      if (!v.wr && (awvalid || wvalid || bready)) excl_bad = 1;
      if (arvalid && !seen_ar) begin
        seen_ar = 1;
        check($sformatf("v%0d araddr", idx), 64'(araddr), 64'(v.addr));
        check($sformatf("v%0d arfields", idx), {arid, arlen, arsize, arburst, arextras},
              {4'h0, 8'h0, 3'd2, 2'd1, 8'h0});
      end
      if (awvalid && !seen_aw) begin
        seen_aw = 1;
        check($sformatf("v%0d awaddr", idx), 64'(awaddr), 64'(v.addr));
        check($sformatf("v%0d awfields", idx), {awid, awlen, awsize, awburst, awextras},
              {4'h0, 8'h0, 3'd2, 2'd1, 8'h0});
      end
      if (wvalid && !seen_w) begin
        seen_w = 1;
        check($sformatf("v%0d wdata", idx), wdata, {v.wd, v.wd});
        check($sformatf("v%0d wstrb_wlast", idx), {wstrb, wlast}, {v.exp_wstrb, 1'b1});
      end
      if (awvalid) awcnt++;
      if (wvalid) wcnt++;
      if (pready) begin
        got = 1; pc = c; got_prdata = prdata; got_err = pslverr;
        psel = 0; penable = 0;
      end
      // AXI responder for the upcoming clock edge
      arready = (c >= v.ar_at) && !ar_d && !v.wr;
      ar_d    = ar_d | (arready && arvalid);
      rvalid  = (c >= v.r_at) && !r_d && !v.wr;
      rdata = v.rd; rresp = v.rresp; rid = v.rid; rlast = v.rlast;
      r_d     = r_d | (rvalid && rready);
      awready = (c >= v.aw_at) && !aw_d && v.wr;
      aw_d    = aw_d | (awready && awvalid);
      wready  = (c >= v.w_at) && !w_d && v.wr;
      w_d     = w_d | (wready && wvalid);
      bvalid  = (c >= v.b_at) && !b_d && v.wr;
      bresp = v.bresp; bid = v.bid;
      b_d     = b_d | (bvalid && bready);
    end
    axi_idle();
    if (!got) begin
      checks++; errors++;
      $display("FAIL v%0d pready_timeout actual=none required=cycle %0d", idx, v.exp_cyc);
    end else begin
      check($sformatf("v%0d pready_cycle", idx), 64'(pc), 64'(v.exp_cyc));
      check($sformatf("v%0d prdata", idx), 64'(got_prdata), 64'(v.exp_prdata));
      check($sformatf("v%0d pslverr", idx), 64'(got_err), 64'(v.exp_err));
      @(negedge clk);
      check($sformatf("v%0d pready_one_cycle", idx), 64'(pready), 64'(0));
    end
    check($sformatf("v%0d one_channel_only", idx), 64'(excl_bad), 64'(0));
    if (v.wr) begin
      check($sformatf("v%0d awvalid_cycles", idx), 64'(awcnt), 64'(v.aw_at));
      check($sformatf("v%0d wvalid_cycles", idx), 64'(wcnt), 64'(v.w_at));
    end
    $display("txn %0d %s addr=%h pready_cycle=%0d prdata=%h pslverr=%0d",
             idx, v.wr ? "WR" : "RD", v.addr, pc, got_prdata, got_err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //        wr addr          wd            strb  rd                      rresp rid rlast bresp bid ar r aw w b drop exp_prdata    err wstrb cyc
    vecs[0] = '{0, 32'h1004, 32'h0,        4'h0, 64'h11223344_55667788, 2'd0, 4'd0, 1, 2'd0, 4'd0, 1, 2, 0, 0, 0, 0, 32'h11223344, 0, 8'h00, 3};
    vecs[1] = '{1, 32'h2000, 32'hCAFEF00D, 4'h3, 64'h0,                 2'd0, 4'd0, 1, 2'd0, 4'd0, 0, 0, 1, 4, 5, 0, 32'h11223344, 0, 8'h03, 6};
    vecs[2] = '{1, 32'h2004, 32'h12345678, 4'hF, 64'h0,                 2'd0, 4'd0, 1, 2'd0, 4'd0, 0, 0, 1, 1, 2, 1, 32'h11223344, 0, 8'hF0, 3};
    vecs[3] = '{0, 32'h3000, 32'h0,        4'h0, 64'h0BAD0BAD_FACEFACE, 2'd2, 4'd0, 1, 2'd0, 4'd0, 3, 1, 0, 0, 0, 0, 32'hFACEFACE, 1, 8'h00, 5};
    vecs[4] = '{0, 32'h300C, 32'h0,        4'h0, 64'h01020304_05060708, 2'd0, 4'd5, 1, 2'd0, 4'd0, 1, 2, 0, 0, 0, 0, 32'h01020304, 1, 8'h00, 3};
    vecs[5] = '{0, 32'h3010, 32'h0,        4'h0, 64'h99999999_87654321, 2'd0, 4'd0, 0, 2'd0, 4'd0, 1, 2, 0, 0, 0, 0, 32'h87654321, 1, 8'h00, 3};
    vecs[6] = '{0, 32'h4000, 32'h0,        4'h0, 64'hFFFF0000_DEADBEEF, 2'd0, 4'd0, 1, 2'd0, 4'd0, 4, 8, 0, 0, 0, 0, 32'hDEADBEEF, 0, 8'h00, 9};
    vecs[7] = '{1, 32'h4008, 32'hA5A55A5A, 4'h9, 64'h0,                 2'd0, 4'd0, 1, 2'd0, 4'd0, 0, 0, 4, 4, 8, 0, 32'hDEADBEEF, 0, 8'h09, 9};
    vecs[8] = '{1, 32'h400C, 32'h0F0F0F0F, 4'h1, 64'h0,                 2'd0, 4'd0, 1, 2'd2, 4'd0, 0, 0, 3, 1, 4, 0, 32'hDEADBEEF, 1, 8'h10, 5};
    vecs[9] = '{1, 32'h4010, 32'h11111111, 4'h2, 64'h0,                 2'd0, 4'd0, 1, 2'd0, 4'd3, 0, 0, 1, 1, 1, 0, 32'hDEADBEEF, 1, 8'h02, 3};

    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    axi_idle();
    repeat (2) @(negedge clk);
    check("reset outputs", {63'(0), pready}, 64'(0));
    check("reset prdata_pslverr", {31'(0), pslverr, prdata}, 64'(0));
    check("reset valids_readies", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'(0));
    rst_n = 1;

    // Setup phase alone must not launch anything.
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("setup_ignored", 64'({arvalid, awvalid, wvalid, pready}), 64'(0));
    end
    psel = 0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset asserted while waiting in RDATA.
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h5000;
    @(negedge clk);
    penable = 1;
    @(negedge clk);  // cycle 1
    check("rst_seq arvalid", 64'(arvalid), 64'(1));
    arready = 1;
    @(negedge clk);  // cycle 2
    arready = 0;
    check("rst_seq rready", 64'(rready), 64'(1));
    #2 rst_n = 0;
    #1;
    check("rst_seq cleared", 64'({rready, pready, arvalid, awvalid, wvalid, bready}), 64'(0));
    psel = 0; penable = 0;
    @(negedge clk);
    check("rst_seq prdata", 64'(prdata), 64'(0));
    rst_n = 1;
    run_vec(vecs[0], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
